// File: rtl/semaforo_pkg.sv
// Shared types, encodings and default durations for the traffic-light controller.
package semaforo_pkg;

    localparam int unsigned TIME_W = 3;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_WALK   = 2'd3
    } state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } car_lamp_t;

    localparam car_lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    localparam car_lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
    localparam car_lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

    localparam logic [TIME_W-1:0] DEF_GREEN_TIME  = 3'd5;
    localparam logic [TIME_W-1:0] DEF_YELLOW_TIME = 3'd2;
    localparam logic [TIME_W-1:0] DEF_RED_TIME    = 3'd4;
    localparam logic [TIME_W-1:0] DEF_WALK_TIME   = 3'd3;

    // WALK keeps the cars stopped, so it shares the RED car lamp.
    function automatic car_lamp_t car_lamp_of(input state_t s);
        car_lamp_t lamp;
        lamp = LAMP_RED;
        case (s)
            ST_GREEN:  lamp = LAMP_GREEN;
            ST_YELLOW: lamp = LAMP_YELLOW;
            default:   lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/semaforo_ctrl_ped_req_latch.sv
// Sticky pedestrian request flag; clear wins over a same-cycle set.
module ped_req_latch (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic clear,
    output logic pending
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (set) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light Moore FSM driving lamps and a downstream duration timer.
// Pedestrian WALK phase is built only when SEMAFORO_PED_EN is defined.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter logic [TIME_W-1:0] GREEN_TIME  = DEF_GREEN_TIME,
    parameter logic [TIME_W-1:0] YELLOW_TIME = DEF_YELLOW_TIME,
    parameter logic [TIME_W-1:0] RED_TIME    = DEF_RED_TIME,
    parameter logic [TIME_W-1:0] WALK_TIME   = DEF_WALK_TIME
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              timer_done,
    input  logic              ped_req,
    output logic              timer_reset,
    output logic [TIME_W-1:0] timer_max,
    output logic              car_red,
    output logic              car_yellow,
    output logic              car_green,
    output logic              walk
);

    state_t            state;
    state_t            next_state_c;
    state_t            target_c;
    logic              state_ok_c;
    logic              advance_c;
    logic              enter_c;
    logic              ped_pending;
    logic [TIME_W-1:0] next_max_c;
    car_lamp_t         lamp_q;

    // timer_reset doubles as the entry flag: timer_done seen during entry is stale.
    assign advance_c = timer_done && !timer_reset;

    always_comb begin
        next_state_c = ST_RED;
        state_ok_c   = 1'b1;
        case (state)
            ST_RED:    next_state_c = ped_pending ? ST_WALK : ST_GREEN;
            ST_GREEN:  next_state_c = ST_YELLOW;
            ST_YELLOW: next_state_c = ST_RED;
`ifdef SEMAFORO_PED_EN
            ST_WALK:   next_state_c = ST_GREEN;
`endif
            default: begin
                next_state_c = ST_RED;
                state_ok_c   = 1'b0;
            end
        endcase
    end

    assign enter_c  = advance_c || !state_ok_c;
    assign target_c = state_ok_c ? next_state_c : ST_RED;

    always_comb begin
        next_max_c = RED_TIME;
        case (target_c)
            ST_GREEN:  next_max_c = GREEN_TIME;
            ST_YELLOW: next_max_c = YELLOW_TIME;
            ST_WALK:   next_max_c = WALK_TIME;
            default:   next_max_c = RED_TIME;
        endcase
    end

    // State plus registered outputs, all loaded together on state entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RED;
            timer_reset <= 1'b1;
            timer_max   <= RED_TIME;
            lamp_q      <= LAMP_RED;
`ifdef SEMAFORO_PED_EN
            walk        <= 1'b0;
`endif
        end else if (enter_c) begin
            state       <= target_c;
            timer_reset <= 1'b1;
            timer_max   <= next_max_c;
            lamp_q      <= car_lamp_of(target_c);
`ifdef SEMAFORO_PED_EN
            walk        <= (target_c == ST_WALK);
`endif
        end else begin
            timer_reset <= 1'b0;
        end
    end

    assign car_red    = lamp_q.red;
    assign car_yellow = lamp_q.yellow;
    assign car_green  = lamp_q.green;

`ifdef SEMAFORO_PED_EN
    ped_req_latch u_ped_req_latch (
        .clock   (clock),
        .reset   (reset),
        .set     (ped_req),
        .clear   (enter_c && (target_c == ST_WALK)),
        .pending (ped_pending)
    );
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_pending    = 1'b0;
    assign walk           = 1'b0;
`endif

endmodule
